// File: rtl/zap_shifter_out_skid.sv
// Two-entry skid register between the barrel shifter and the ALU input stage.
// o_ready, o_valid and o_count decode straight from the state flop, so ALU back-pressure never reaches the shifter combinationally.
module zap_shifter_out_skid #(
    parameter int TAG_W         = 6,
    parameter bit RESET_PAYLOAD = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_clear,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_result,
    input  logic             i_carry,
    input  logic             i_sat,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_result,
    output logic             o_carry,
    output logic             o_sat,
    output logic [TAG_W-1:0] o_tag,
    output logic [1:0]       o_count,
    input  logic             i_sticky_clr,
    output logic             o_sat_sticky
);

    localparam int PW = 32 + 1 + 1 + TAG_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          accept, emit;
    logic          load_main, load_skid, move_skid;
    logic [PW-1:0] in_pl, main_pl, skid_pl;

    assign o_valid = (state != EMPTY);
    assign o_ready = (state != FULL);
    assign o_count = state;

    assign accept = i_valid & o_ready;
    assign emit   = o_valid & i_ready;

    assign in_pl = {i_result, i_carry, i_sat, i_tag};
    assign {o_result, o_carry, o_sat, o_tag} = main_pl;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= EMPTY;
        else            state <= state_nxt;
    end

    // Clear wins over everything; payload loads stay off so a flushed input is dropped.
    always_comb begin
        state_nxt = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        if (i_clear) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        load_main = 1'b1;
                        state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_nxt = FULL;
                    end else if (emit) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (emit) begin
                        move_skid = 1'b1;
                        state_nxt = ONE;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    generate
        if (RESET_PAYLOAD) begin : g_pl_rst
            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    main_pl <= '0;
                    skid_pl <= '0;
                end else begin
                    if (load_main)      main_pl <= in_pl;
                    else if (move_skid) main_pl <= skid_pl;
                    if (load_skid)      skid_pl <= in_pl;
                end
            end
        end else begin : g_pl_norst
            always_ff @(posedge i_clk) begin
                if (load_main)      main_pl <= in_pl;
                else if (move_skid) main_pl <= skid_pl;
                if (load_skid)      skid_pl <= in_pl;
            end
        end
    endgenerate

    // Set beats clear so a saturation leaving in the clear cycle is not lost.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)          o_sat_sticky <= 1'b0;
        else if (emit && o_sat)  o_sat_sticky <= 1'b1;
        else if (i_sticky_clr)   o_sat_sticky <= 1'b0;
    end

`ifndef SYNTHESIS
    always @(posedge i_clk) begin
        if (i_reset_n) begin
            assert (!$isunknown({i_valid, i_ready, i_clear}));
        end
    end
`endif

endmodule
